// File: rtl/rot_sched.sv
// Round-robin scheduler that shares one single-step 8-bit rotator between two requesters.
// Optional macro ROT_SCHED_SHORTCUT_EN: rotations with amt > 4 run 8-amt steps in the opposite direction.
module rot_sched #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_dir,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_dir,
    input  logic [AMT_W-1:0] req1_amt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic [AMT_W-1:0] cnt_q;
    logic             id_q;
    logic             last_grant_q;

    logic             any_valid;
    logic             accept;
    logic             win_id;
    logic [WIDTH-1:0] win_data;
    logic             win_dir;
    logic [AMT_W-1:0] win_amt;
    logic             load_dir;
    logic [AMT_W-1:0] load_cnt;

    function automatic logic [WIDTH-1:0] rot_right1(input logic [WIDTH-1:0] d);
        return {d[0], d[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] reverse(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

    // The datapath only rotates right; a left step is mirrored around it.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic dir);
        return dir ? rot_right1(d) : reverse(rot_right1(reverse(d)));
    endfunction

    // Arbitration: a lone requester wins; on contention the one not granted last time wins.
    assign any_valid  = req0_valid | req1_valid;
    assign accept     = (state_q == IDLE) && any_valid;
    assign win_id     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign win_data   = win_id ? req1_data : req0_data;
    assign win_dir    = win_id ? req1_dir  : req0_dir;
    assign win_amt    = win_id ? req1_amt  : req0_amt;
    assign req0_ready = accept & ~win_id;
    assign req1_ready = accept & win_id;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        load_dir = win_dir;
        load_cnt = win_amt;
`ifdef ROT_SCHED_SHORTCUT_EN
        if (win_amt > AMT_W'(WIDTH / 2)) begin
            load_dir = ~win_dir;
            load_cnt = AMT_W'(WIDTH - int'(win_amt));
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (load_cnt == '0) ? RESP : ROT;
            ROT:  if (cnt_q == AMT_W'(1)) state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            data_q       <= '0;
            dir_q        <= 1'b0;
            cnt_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q       <= win_data;
                dir_q        <= load_dir;
                cnt_q        <= load_cnt;
                id_q         <= win_id;
                last_grant_q <= win_id;
            end else if (state_q == ROT) begin
                data_q <= step(data_q, dir_q);
                cnt_q  <= cnt_q - AMT_W'(1);
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rot_sched.sv
// Self-checking bench for rot_sched: directed cases plus randomized traffic against a behavioural model.
module tb_rot_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_dir;
    logic [7:0] req0_data;
    logic [2:0] req0_amt;
    logic       req1_valid, req1_ready, req1_dir;
    logic [7:0] req1_data;
    logic [2:0] req1_amt;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0] rsp_data;

    rot_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_dir   (req0_dir),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_dir   (req1_dir),
        .req1_amt   (req1_amt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Pending request held by each requester, plus the model's memory of the last grant.
    bit         pend[2];
    logic [7:0] pdat[2];
    bit         pdir[2];
    logic [2:0] pamt[2];
    int         mdl_last;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Rotation as plain arithmetic: a left rotate by k is a right rotate by 8-k.
    function automatic logic [7:0] ref_rot(input logic [7:0] d, input bit dir, input int amt);
        int k, x;
        k = dir ? amt : (8 - amt) % 8;
        x = int'(d);
        return 8'(((x >> k) | (x << (8 - k))) & 255);
    endfunction

    function automatic int ref_steps(input int amt);
`ifdef ROT_SCHED_SHORTCUT_EN
        return (amt > 4) ? 8 - amt : amt;
`else
        return amt;
`endif
    endfunction

    function automatic int ref_winner();
        if (pend[0] && pend[1]) return 1 - mdl_last;
        return pend[0] ? 0 : 1;
    endfunction

    task automatic apply();
        req0_valid = pend[0]; req0_data = pdat[0]; req0_dir = pdir[0]; req0_amt = pamt[0];
        req1_valid = pend[1]; req1_data = pdat[1]; req1_dir = pdir[1]; req1_amt = pamt[1];
    endtask

    task automatic set_req(input int id, input logic [7:0] d, input bit dir, input logic [2:0] amt);
        pend[id] = 1'b1; pdat[id] = d; pdir[id] = dir; pamt[id] = amt;
    endtask

    task automatic set_random(input int id);
        set_req(id, 8'($urandom), 1'($urandom), 3'($urandom));
    endtask

    // Starts and ends just after a falling edge; the ending cycle is the IDLE cycle after a handshake.
    task automatic wait_grant(output bit got, output int id);
        got = 1'b0;
        id  = 0;
        apply();
        #1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            if (req0_ready || req1_ready) begin
                got = 1'b1;
                id  = req1_ready ? 1 : 0;
                break;
            end
        end
        check("grant_seen", int'(got), 1);
        if (got) check("grant_onehot", int'(req0_ready & req1_ready), 0);
    endtask

    task automatic serve_one(input int hold, input bit inj, output int won);
        bit         got;
        int         w, lat;
        logic [7:0] exp_d;
        logic [7:0] held_d;
        logic       held_id;
        w = ref_winner();
        wait_grant(got, won);
        if (!got) return;
        check("grant_id", won, w);
        exp_d    = ref_rot(pdat[w], pdir[w], int'(pamt[w]));
        pend[w]  = 1'b0;
        mdl_last = w;
        @(posedge clk);
        #1 apply();
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        check("rsp_latency", lat, 1 + ref_steps(int'(pamt[w])));
        check("rsp_data", int'(rsp_data), int'(exp_d));
        check("rsp_id", int'(rsp_id), w);
        held_d  = rsp_data;
        held_id = rsp_id;
        for (int h = 0; h < hold; h++) begin
            if (inj && h == 1 && !pend[1-w]) begin
                set_random(1 - w);
                apply();
            end
            @(negedge clk);
            #1;
            check("hold_valid", int'(rsp_valid), 1);
            check("hold_data", int'(rsp_data), int'(held_d));
            check("hold_id", int'(rsp_id), int'(held_id));
            check("hold_no_ready", int'(req0_ready | req1_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        #1;
        check("post_idle_busy", int'(busy), 0);
        check("post_idle_valid", int'(rsp_valid), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        apply();
        mdl_last = 1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", int'(rsp_valid), 0);
        check("rst_data", int'(rsp_data), 0);
        check("rst_id", int'(rsp_id), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(req0_ready | req1_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int  won;
        bit  got;
        bit  seen_rsp;
        rsp_ready = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        pdat[0] = '0; pdat[1] = '0; pdir[0] = 1'b0; pdir[1] = 1'b0; pamt[0] = '0; pamt[1] = '0;
        do_reset();

        set_req(0, 8'h81, 1'b1, 3'd1);
        serve_one(0, 1'b0, won);
        set_req(1, 8'h81, 1'b0, 3'd3);
        serve_one(0, 1'b0, won);
        set_req(0, 8'h96, 1'b1, 3'd0);
        serve_one(0, 1'b0, won);

        // Simultaneous requests after reset, req0 re-asserting: order must be 0, 1, 0.
        do_reset();
        set_req(0, 8'h3C, 1'b1, 3'd2);
        set_req(1, 8'hA5, 1'b0, 3'd5);
        serve_one(0, 1'b0, won);
        check("order_first", won, 0);
        set_req(0, 8'h0F, 1'b0, 3'd4);
        serve_one(1, 1'b0, won);
        check("order_second", won, 1);
        serve_one(0, 1'b0, won);
        check("order_third", won, 0);

        // Back-pressure with a competing request arriving during RESP.
        set_req(0, 8'hC3, 1'b1, 3'd6);
        serve_one(5, 1'b1, won);
        serve_one(0, 1'b0, won);
        check("late_req_id", won, 1);

        set_req(0, 8'h01, 1'b1, 3'd7);
        serve_one(0, 1'b0, won);

        // Abort mid-rotation with reset.
        set_req(0, 8'h01, 1'b1, 3'd7);
        wait_grant(got, won);
        pend[0] = 1'b0;
        @(posedge clk);
        #1 apply();
        @(negedge clk);
        #1;
        check("abort_in_rot_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_valid", int'(rsp_valid), 0);
        check("abort_data", int'(rsp_data), 0);
        check("abort_id", int'(rsp_id), 0);
        check("abort_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_last = 1;
        seen_rsp = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp = 1'b1;
        end
        #1;
        check("abort_no_rsp", int'(seen_rsp), 0);

        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) set_random(r);
            end
            if (!pend[0] && !pend[1]) set_random(int'($urandom_range(0, 1)));
            serve_one(int'($urandom_range(0, 3)), 1'($urandom), won);
        end
        while (pend[0] || pend[1]) serve_one(0, 1'b0, won);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
